// File: rtl/usr_pkg.sv
// usr_pkg: mode encoding and reset value shared by the universal shift register.
package usr_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_e;
    localparam logic USR_RESET_VAL = 1'b0;
endpackage

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold / shift right / shift left / parallel load register.
// Optional serial outputs so_right/so_left when USR_SERIAL_OUT_EN is defined.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_right,
    input  logic             s_left,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] p_dout,
    output logic [WIDTH-1:0] p_dout_bar
`ifdef USR_SERIAL_OUT_EN
    ,
    output logic             so_right,
    output logic             so_left
`endif
);
    logic [WIDTH-1:0] q_q, q_d;
    // Undecoded select values (X/Z) fall to the default branch and hold.
    always_comb begin
        q_d = q_q;
        case (s)
            MODE_SHR:  q_d = {s_right, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], s_left};
            MODE_LOAD: q_d = p_din;
            default:   q_d = q_q;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= {WIDTH{USR_RESET_VAL}};
        else     q_q <= q_d;
    assign p_dout     = q_q;
    assign p_dout_bar = ~q_q;
`ifdef USR_SERIAL_OUT_EN
    assign so_right = q_q[0];
    assign so_left  = q_q[WIDTH-1];
`endif
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed vectors with hand-computed expectations.
module tb_universal_shift_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] p_din = '0;
    logic       s_right = 1'b0;
    logic       s_left = 1'b0;
    logic [1:0] s = 2'b00;
    logic [3:0] p_dout, p_dout_bar;
    int         n_cmp = 0;
    int         n_bad = 0;
`ifdef USR_SERIAL_OUT_EN
    logic so_right, so_left;
`endif
    universal_shift_reg #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .p_din(p_din), .s_right(s_right), .s_left(s_left),
        .s(s), .p_dout(p_dout), .p_dout_bar(p_dout_bar)
`ifdef USR_SERIAL_OUT_EN
        , .so_right(so_right), .so_left(so_left)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [3:0] shr_exp [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        logic [3:0] shl_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
        s = 2'b11; p_din = 4'b0110;
        step();
        chk("pre_reset_load", p_dout, 4'b0110);
        rst = 1'b1;
        #1;
        chk("async_rst_dout", p_dout, 4'b0000);
        chk("async_rst_bar", p_dout_bar, 4'b1111);
        p_din = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold_%0d", i), p_dout, 4'b0000);
        end
        rst = 1'b0;
        p_din = 4'b1011;
        step();
        chk("load_dout", p_dout, 4'b1011);
        chk("load_bar", p_dout_bar, 4'b0100);
        s = 2'b00; p_din = 4'b0110; s_right = 1'b1; s_left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_%0d", i), p_dout, 4'b1011);
        end
        s = 2'b11; p_din = 4'b0000;
        step();
        chk("load_zero", p_dout, 4'b0000);
        s = 2'b01; s_right = 1'b1; s_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_left = ~s_left;
            step();
            chk($sformatf("shr_%0d", i), p_dout, shr_exp[i]);
        end
        s_right = 1'b0;
        step();
        chk("shr_zero_in", p_dout, 4'b0111);
        s = 2'b11; p_din = 4'b0001;
        step();
        chk("load_0001", p_dout, 4'b0001);
        s = 2'b10; s_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_right = ~s_right;
            step();
            chk($sformatf("shl_%0d", i), p_dout, shl_exp[i]);
        end
        s = 2'b11; p_din = 4'b1111;
        step();
        s = 2'b10; s_left = 1'b0;
        step();
        chk("shl_before_rst", p_dout, 4'b1110);
        #2 rst = 1'b1;
        #1;
        chk("mid_op_rst", p_dout, 4'b0000);
        chk("mid_op_rst_bar", p_dout_bar, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        s = 2'b11; p_din = 4'b0101;
        step();
        chk("first_after_rst", p_dout, 4'b0101);
        s = 2'bxx; p_din = 4'b1010;
        step();
        chk("x_select_holds", p_dout, 4'b0101);
`ifdef USR_SERIAL_OUT_EN
        s = 2'b11; p_din = 4'b1001;
        step();
        chk("so_load_right", {3'b000, so_right}, 4'b0001);
        chk("so_load_left", {3'b000, so_left}, 4'b0001);
        s = 2'b01; s_right = 1'b0;
        step();
        chk("so_shr_q", p_dout, 4'b0100);
        chk("so_shr_right", {3'b000, so_right}, 4'b0000);
        chk("so_shr_left", {3'b000, so_left}, 4'b0000);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
